// File: rtl/wb_burst_master.sv
// wb_burst_master
//   Wishbone classic initiator. A local command (address, word count,
//   direction) becomes a locked burst of single-word handshakes. Each
//   handshake holds stb until ack, then waits for ack to fall before the
//   next strobe.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   cmd_*               command channel (vld/rdy handshake, we, adr, len)
//   wr_dat/vld/rdy      write word stream into the master
//   rd_dat/rd_vld       read word stream out of the master (no backpressure)
//   done/err            completion pulse, err=1 when aborted by timeout
//   busy                state is not IDLE
//   slv_int             one-cycle pulse per rising edge of wbm_int_i
//   wbm_*               Wishbone master side
module wb_burst_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned LEN_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_vld,
    output logic                 cmd_rdy,
    input  logic                 cmd_we,
    input  logic [31:0]          cmd_adr,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic [31:0]          wr_dat,
    input  logic                 wr_vld,
    output logic                 wr_rdy,
    output logic [31:0]          rd_dat,
    output logic                 rd_vld,
    output logic                 done,
    output logic                 err,
    output logic                 busy,
    output logic                 slv_int,
    output logic                 wbm_we_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_cyc_o,
    output logic [31:0]          wbm_adr_o,
    output logic [31:0]          wbm_dat_o,
    input  logic [31:0]          wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_int_i
);

    typedef enum logic [2:0] {IDLE, WDATA, STROBE, RELEASE, FINISH} state_t;

    // Counter compares against the last allowed cycle, so a phase lasts
    // exactly TIMEOUT_CYCLES cycles before the abort.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic [LEN_WIDTH-1:0] left_q, left_d;
    logic                 we_q, we_d;
    logic                 err_q, err_d;
    logic [15:0]          tmo_q, tmo_d;
    logic                 int_q, int_pulse_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            left_q      <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            int_q       <= 1'b0;
            int_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            left_q      <= left_d;
            we_q        <= we_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            int_q       <= wbm_int_i;
            int_pulse_q <= wbm_int_i & ~int_q;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        left_d  = left_q;
        we_d    = we_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (cmd_vld) begin
                    adr_d  = cmd_adr;
                    left_d = cmd_len;
                    we_d   = cmd_we;
                    err_d  = 1'b0;
                    tmo_d  = '0;
                    if (cmd_len == '0)  state_d = FINISH;
                    else if (cmd_we)    state_d = WDATA;
                    else                state_d = STROBE;
                end
            end
            WDATA: begin
                if (wr_vld) begin
                    dat_d   = wr_dat;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                if (wbm_ack_i) begin
                    left_d  = left_q - LEN_WIDTH'(1);
                    adr_d   = adr_q + 32'd1;
                    tmo_d   = '0;
                    state_d = RELEASE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            RELEASE: begin
                // Next strobe only once the slave has dropped ack.
                if (!wbm_ack_i) begin
                    tmo_d = '0;
                    if (left_q == '0) state_d = FINISH;
                    else if (we_q)    state_d = WDATA;
                    else              state_d = STROBE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cmd_rdy is gated by rst so it reads 0 while reset is held.
    assign cmd_rdy   = rst & (state_q == IDLE);
    assign wr_rdy    = (state_q == WDATA);
    assign rd_vld    = (state_q == STROBE) & wbm_ack_i & ~we_q;
    assign rd_dat    = rd_vld ? wbm_dat_i : '0;
    assign done      = (state_q == FINISH);
    assign err       = err_q;
    assign busy      = (state_q != IDLE);
    assign slv_int   = int_pulse_q;
    assign wbm_stb_o = (state_q == STROBE);
    assign wbm_cyc_o = (state_q == WDATA) | (state_q == STROBE) | (state_q == RELEASE);
    assign wbm_we_o  = we_q & wbm_cyc_o;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_burst_master.sv
module tb_wb_burst_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_vld = 1'b0, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [15:0] cmd_len = '0;
    logic [31:0] wr_dat = '0;
    logic        wr_vld = 1'b0;
    logic        cmd_rdy, wr_rdy, rd_vld, done, err, busy, slv_int;
    logic [31:0] rd_dat;
    logic        wbm_we_o, wbm_stb_o, wbm_cyc_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_int_i = 1'b0;

    wb_burst_master #(.TIMEOUT_CYCLES(8), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wr_dat(wr_dat), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
        .rd_dat(rd_dat), .rd_vld(rd_vld),
        .done(done), .err(err), .busy(busy), .slv_int(slv_int),
        .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_int_i(wbm_int_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Slave model configuration (written only by the stimulus process).
    int          ack_dly  = 1;
    int          ack_hold = 0;
    bit          never    = 1'b0;
    logic [31:0] rd_base  = '0;

    // Slave: ack ack_dly cycles after seeing stb, keep ack ack_hold extra
    // cycles after stb falls. Read data encodes the beat number.
    int dly = 0, hcnt = 0;
    always @(posedge clk) begin
        if (wbm_stb_o && !wbm_ack_i) begin
            hcnt <= 0;
            if (!never) begin
                if (dly >= ack_dly - 1) begin
                    wbm_ack_i <= 1'b1;
                    dly       <= 0;
                    wbm_dat_i <= {16'hA5A5, 16'(wbm_adr_o - rd_base + 32'd1)};
                end else begin
                    dly <= dly + 1;
                end
            end
        end else if (wbm_ack_i && !wbm_stb_o) begin
            if (hcnt >= ack_hold) begin
                wbm_ack_i <= 1'b0;
                hcnt      <= 0;
            end else begin
                hcnt <= hcnt + 1;
            end
        end
    end

    // Monitor on the falling edge: logs strobes, read words, done pulses.
    logic [31:0] s_adr [256];
    logic [31:0] s_dat [256];
    logic        s_we  [256];
    logic [31:0] r_dat [256];
    int n_stb = 0, n_rd = 0, n_done = 0, n_gap = 0, n_viol = 0, n_hi = 0, n_int = 0;
    logic last_err = 1'b0;
    logic stb_prev = 1'b0;
    always @(negedge clk) begin
        if (wbm_stb_o && !stb_prev) begin
            s_adr[n_stb & 255] = wbm_adr_o;
            s_dat[n_stb & 255] = wbm_dat_o;
            s_we[n_stb & 255]  = wbm_we_o;
            if (wbm_ack_i) n_viol++;
            n_stb++;
        end
        if (wbm_stb_o) n_hi++;
        if (rd_vld) begin
            r_dat[n_rd & 255] = rd_dat;
            n_rd++;
        end
        if (done) begin
            n_done++;
            last_err = err;
        end
        if (busy && !wbm_cyc_o && !done) n_gap++;
        if (slv_int) n_int++;
        stb_prev = wbm_stb_o;
    end

    task automatic issue_cmd(input logic we, input logic [31:0] adr, input int len,
                             output logic done_next);
        int t = 0;
        @(negedge clk);
        cmd_we = we; cmd_adr = adr; cmd_len = 16'(len); cmd_vld = 1'b1;
        while (!cmd_rdy && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("cmd_rdy_wait", 32'(t), 0);
        @(negedge clk);
        cmd_vld   = 1'b0;
        done_next = done;
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (n_done == d0 && t < 400) begin @(posedge clk); t++; end
        if (t >= 400) chk("done_wait", 32'(n_done - d0), 1);
        @(negedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic we, input logic [31:0] adr, input int len);
        logic dn;
        int d0 = n_done;
        issue_cmd(we, adr, len, dn);
        if (we) begin
            for (int k = 0; k < len; k++) begin
                int t = 0;
                repeat (2) @(negedge clk);
                wr_dat = 32'(k + 1);
                wr_vld = 1'b1;
                while (!wr_rdy && t < 200) begin @(negedge clk); t++; end
                if (t >= 200) begin
                    chk("wr_rdy_wait", 32'(t), 0);
                    wr_vld = 1'b0;
                    break;
                end
                @(negedge clk);
                wr_vld = 1'b0;
            end
        end
        wait_done(d0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        int          len;
        int          dly;
        int          hold;
        logic        exp_err;   // 1: slave never acks, abort expected
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic dn;
        int s0, r0, d0, g0, v0, h0, i0, exp_n;
        bit rdy_seen;

        vecs[0] = '{1'b0, 32'h0000_0010, 1, 3, 0, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFF_FFFE, 4, 1, 0, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0100, 2, 1, 5, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0040, 3, 1, 0, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0200, 2, 2, 1, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0300, 3, 2, 3, 1'b0};

        // Reset state.
        #2;
        chk("rst_ctl", {22'd0, cmd_rdy, wr_rdy, rd_vld, done, err, busy, slv_int,
                        wbm_stb_o, wbm_cyc_o, wbm_we_o}, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_dat", wbm_dat_o | rd_dat, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rdy_after_rst", {31'd0, cmd_rdy}, 1);
        chk("busy_after_rst", {31'd0, busy}, 0);

        // Table-driven bursts.
        foreach (vecs[v]) begin
            ack_dly = vecs[v].dly; ack_hold = vecs[v].hold;
            never = vecs[v].exp_err; rd_base = vecs[v].adr;
            s0 = n_stb; r0 = n_rd; d0 = n_done; g0 = n_gap; v0 = n_viol; h0 = n_hi;
            run_cmd(vecs[v].we, vecs[v].adr, vecs[v].len);
            exp_n = vecs[v].exp_err ? 1 : vecs[v].len;
            chk($sformatf("v%0d_nstb", v), 32'(n_stb - s0), 32'(exp_n));
            chk($sformatf("v%0d_ndone", v), 32'(n_done - d0), 1);
            chk($sformatf("v%0d_err", v), {31'd0, last_err}, {31'd0, vecs[v].exp_err});
            chk($sformatf("v%0d_cyc_gap", v), 32'(n_gap - g0), 0);
            chk($sformatf("v%0d_stb_ack_overlap", v), 32'(n_viol - v0), 0);
            chk($sformatf("v%0d_stb_cycles", v), 32'(n_hi - h0),
                vecs[v].exp_err ? 32'd8 : 32'(vecs[v].len * (vecs[v].dly + 1)));
            chk($sformatf("v%0d_nrd", v), 32'(n_rd - r0),
                (vecs[v].we || vecs[v].exp_err) ? 32'd0 : 32'(vecs[v].len));
            for (int i = 0; i < exp_n && i < n_stb - s0; i++) begin
                chk($sformatf("v%0d_adr%0d", v, i), s_adr[(s0 + i) & 255], vecs[v].adr + 32'(i));
                chk($sformatf("v%0d_we%0d", v, i), {31'd0, s_we[(s0 + i) & 255]}, {31'd0, vecs[v].we});
                if (vecs[v].we)
                    chk($sformatf("v%0d_wdat%0d", v, i), s_dat[(s0 + i) & 255], 32'(i + 1));
                else if (!vecs[v].exp_err)
                    chk($sformatf("v%0d_rdat%0d", v, i), r_dat[(r0 + i) & 255],
                        {16'hA5A5, 16'(i + 1)});
            end
            chk($sformatf("v%0d_idle", v), {30'd0, busy, wbm_cyc_o}, 0);
        end

        // len=0: done the cycle after accept, no bus activity.
        never = 1'b0; ack_dly = 1; ack_hold = 0;
        s0 = n_stb; d0 = n_done;
        issue_cmd(1'b0, 32'h0000_0080, 0, dn);
        chk("len0_done_next", {31'd0, dn}, 1);
        chk("len0_no_cyc", {31'd0, wbm_cyc_o}, 0);
        wait_done(d0);
        chk("len0_nstb", 32'(n_stb - s0), 0);
        chk("len0_err", {31'd0, last_err}, 0);

        // Commands presented while busy are ignored.
        ack_dly = 4; rd_base = 32'h0000_0700;
        s0 = n_stb; d0 = n_done;
        issue_cmd(1'b0, 32'h0000_0700, 3, dn);
        cmd_we = 1'b1; cmd_adr = 32'h0000_0999; cmd_len = 16'd5; cmd_vld = 1'b1;
        rdy_seen = 1'b0;
        repeat (6) begin @(negedge clk); if (cmd_rdy) rdy_seen = 1'b1; end
        cmd_vld = 1'b0;
        chk("busy_rdy_low", {31'd0, rdy_seen}, 0);
        wait_done(d0);
        repeat (20) @(negedge clk);
        #1;
        chk("busy_nstb", 32'(n_stb - s0), 3);
        chk("busy_ndone", 32'(n_done - d0), 1);
        chk("busy_last_adr", s_adr[(s0 + 2) & 255], 32'h0000_0702);

        // Asynchronous reset mid-burst.
        never = 1'b1;
        d0 = n_done;
        issue_cmd(1'b0, 32'h0000_0500, 3, dn);
        @(negedge clk);
        chk("rst_mid_stb_before", {31'd0, wbm_stb_o}, 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_outs", {27'd0, wbm_stb_o, wbm_cyc_o, busy, done, cmd_rdy}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid_rdy", {31'd0, cmd_rdy}, 1);
        chk("rst_mid_no_done", 32'(n_done - d0), 0);
        never = 1'b0;

        // Interrupt edge reporting.
        i0 = n_int;
        @(negedge clk); wbm_int_i = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("int_first", 32'(n_int - i0), 1);
        wbm_int_i = 1'b0;
        repeat (2) @(negedge clk);
        wbm_int_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("int_second", 32'(n_int - i0), 2);
        wbm_int_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
